serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame (range 1..16).
REQ-002 SHALL have parameter CLK_DIV, default 4, clk cycles per serial bit (range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port tx_data  input  DATA_W  parallel word to send; sampled only on handshake.
REQ-006 SHALL have port tx_valid  input  1  producer offers tx_data.
REQ-007 SHALL have port tx_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port tx_line  output  1  serial line; idle level 1.
REQ-009 SHALL have port busy  output  1  frame in progress (any state except IDLE).

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-011 SHALL assert tx_ready only in IDLE; handshake = tx_valid && tx_ready at a rising edge.
REQ-012 SHALL latch tx_data into an internal shift register on handshake; later tx_data changes are ignored until the next handshake.
REQ-013 SHALL drive tx_line from a register; the start bit (0) appears on the cycle after the handshake.
REQ-014 SHALL hold every bit for exactly CLK_DIV cycles using a divide counter that restarts at each bit boundary.
REQ-015 SHALL send the data bits LSB first in DATA, using a bit counter that advances 0..DATA_W-1.
REQ-016 SHALL send the stop bit as 1 for CLK_DIV cycles, then enter IDLE.
REQ-017 SHALL have a frame length of (DATA_W+2)*CLK_DIV cycles, plus CLK_DIV with parity; tx_ready rises on the cycle after the last stop cycle.
REQ-018 SHALL keep tx_line=1 in IDLE; consecutive frames are separated by at least one idle cycle.
REQ-019 SHALL ignore tx_valid while busy; no queuing and no data loss, since the producer holds the word until tx_ready.
REQ-020 SHALL support CLK_DIV=1, giving one cycle per bit with no divide-counter wrap hazard.
REQ-021 SHALL size the divide and bit counters as $clog2 of their range (minimum 1 bit) and wrap them only through an explicit reload.

Reset
REQ-022 SHALL, when rst_n=0 at a rising edge, set state IDLE, tx_line=1, tx_ready=1, busy=0, and clear the counters and shift register to 0.
REQ-023 SHALL, if reset occurs mid-frame, abort the frame: tx_line returns to 1 at that edge and the word is not resent.
REQ-024 SHALL give reset priority over a handshake in the same cycle.

Configuration
REQ-025 SHALL use macro SERIAL_TX_PARITY_EN; when defined, a PARITY state between DATA and STOP sends the even-parity bit (XOR of the data bits) for CLK_DIV cycles.
REQ-026 SHALL, without SERIAL_TX_PARITY_EN, go DATA -> STOP directly, with no parity logic or state encoding present.

Structure
REQ-027 SHALL place the FSM state encoding and the constants START_BIT=0, STOP_BIT=1 and IDLE_LEVEL=1 in shared package serial_pkg; a future serial_rx will use the same package.
REQ-028 SHALL place the load/shift register (parallel load, right shift, LSB out) in a sub-module serial_tx_shreg.

Verification (DATA_W=8, CLK_DIV=4 unless stated)
REQ-029 SHALL check: reset then tx_data=8'hA5, tx_valid pulse -> tx_line shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total, busy high throughout; tx_ready=1 on cycle 41.
REQ-030 SHALL check: tx_valid held high with words 8'h00 then 8'hFF -> two frames, second start bit no earlier than 1 idle cycle after the first stop bit; line 0 for 36 cycles, then 1, then frame 2.
REQ-031 SHALL check: tx_data changed to 8'h3C two cycles after accepting 8'hC3 -> line carries 8'hC3 bits (1,1,0,0,0,0,1,1 LSB first).
REQ-032 SHALL check: rst_n=0 during DATA bit 3 -> next edge tx_line=1, busy=0, tx_ready=1; after release, new word 8'h01 is sent cleanly.
REQ-033 SHALL check: CLK_DIV=1, tx_data=8'h81 -> 10-cycle frame 0,1,0,0,0,0,0,0,1,1.
REQ-034 SHALL check: SERIAL_TX_PARITY_EN defined, 8'h07 -> parity bit 1, 44-cycle frame; 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared serial link definitions: FSM encoding and line levels (PARITY state only with SERIAL_TX_PARITY_EN).
// Used by serial_tx today and by the future receiver.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef SERIAL_TX_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Counter width for a 0..range-1 count, never narrower than one bit.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_shreg.sv
// Payload shift register: parallel load, right shift, LSB presented; no latency beyond the load edge.
// No backpressure: load and shift are strobes from the owning FSM.
module serial_tx_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         lsb
);

    logic [W-1:0] q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= q >> 1;
        end
    end

    assign lsb = q[0];

endmodule

// File: rtl/serial_tx.sv
// Serial frame transmitter: start, DATA_W bits LSB first, optional even parity (SERIAL_TX_PARITY_EN), stop; start bit one cycle after handshake.
// Backpressure: tx_ready is high only in IDLE, so a held tx_valid waits out the whole frame.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_line,
    output logic              busy
);

    localparam int DIV_W = cnt_width(CLK_DIV);
    localparam int BIT_W = cnt_width(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               handshake;
    logic               bit_end;
    logic               last_bit;
    logic               sh_shift;
    logic               sh_lsb;
`ifdef SERIAL_TX_PARITY_EN
    logic               parity_q;
`endif

    assign handshake = tx_valid && tx_ready;
    assign bit_end   = (div_cnt == DIV_LAST);
    assign last_bit  = (bit_cnt == BIT_LAST);
    // The register shifts on the same edge its LSB is copied onto the line.
    assign sh_shift  = bit_end && ((state == START) || ((state == DATA) && !last_bit));

    serial_tx_shreg #(
        .W (DATA_W)
    ) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (handshake),
        .shift (sh_shift),
        .din   (tx_data),
        .lsb   (sh_lsb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_line  <= IDLE_LEVEL;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state    <= START;
                        tx_line  <= START_BIT;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
`ifdef SERIAL_TX_PARITY_EN
                        parity_q <= ^tx_data;
`endif
                    end
                end
                default: begin
                    if (!bit_end) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        case (state)
                            START: begin
                                state   <= DATA;
                                tx_line <= sh_lsb;
                                bit_cnt <= '0;
                            end
                            DATA: begin
                                if (last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
                                    state   <= PARITY;
                                    tx_line <= parity_q;
`else
                                    state   <= STOP;
                                    tx_line <= STOP_BIT;
`endif
                                end else begin
                                    bit_cnt <= bit_cnt + BIT_W'(1);
                                    tx_line <= sh_lsb;
                                end
                            end
`ifdef SERIAL_TX_PARITY_EN
                            PARITY: begin
                                state   <= STOP;
                                tx_line <= STOP_BIT;
                            end
`endif
                            default: begin
                                state    <= IDLE;
                                tx_line  <= IDLE_LEVEL;
                                tx_ready <= 1'b1;
                                busy     <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: DATA_W=8 with CLK_DIV=4 (main instance) and CLK_DIV=1.
module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data, tx_data1;
    logic       tx_valid, tx_valid1;
    logic       tx_ready, tx_line, busy;
    logic       tx_ready1, tx_line1, busy1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(8), .CLK_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_line(tx_line), .busy(busy)
    );

    serial_tx #(.DATA_W(8), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .tx_line(tx_line1), .busy(busy1)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] alt;
        logic [0:9] seq;
        logic       par;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Inserts the parity bit ahead of the stop bit when parity is built in.
    function automatic logic [0:10] mk(input logic [0:9] s, input logic p);
        logic [0:10] r;
`ifdef SERIAL_TX_PARITY_EN
        r = {s[0:8], p, s[9]};
`else
        r = {s, p};
`endif
        return r;
    endfunction

    // Entered at the falling edge of frame cycle 1; leaves at the cycle after the last stop cycle.
    task automatic expect_frame(input logic [0:10] s, input logic [7:0] alt, input string nm);
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < DIV; c++) begin
                if (b * DIV + c == 2) tx_data = alt;
                chk($sformatf("%s line b%0d c%0d", nm, b, c), tx_line, s[b]);
                chk($sformatf("%s busy b%0d c%0d", nm, b, c), busy, 1'b1);
                chk($sformatf("%s ready b%0d c%0d", nm, b, c), tx_ready, 1'b0);
                @(negedge clk);
            end
        end
        chk({nm, " ready after"}, tx_ready, 1'b1);
        chk({nm, " busy after"}, busy, 1'b0);
        chk({nm, " idle line"}, tx_line, 1'b1);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [7:0] alt,
                             input logic [0:10] s, input string nm);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        expect_frame(s, alt, nm);
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, alt: 8'h5A, seq: 10'b0101001011, par: 1'b0};
        vecs[1] = '{data: 8'hC3, alt: 8'h3C, seq: 10'b0110000111, par: 1'b0};
        vecs[2] = '{data: 8'h07, alt: 8'hF8, seq: 10'b0111000001, par: 1'b1};
        vecs[3] = '{data: 8'h03, alt: 8'hFC, seq: 10'b0110000001, par: 1'b0};
        vecs[4] = '{data: 8'h5A, alt: 8'hA5, seq: 10'b0010110101, par: 1'b0};

        rst_n = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        tx_data1 = 8'h00; tx_valid1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset line", tx_line, 1'b1);
        chk("reset ready", tx_ready, 1'b1);
        chk("reset busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            run_frame(vecs[i].data, vecs[i].alt, mk(vecs[i].seq, vecs[i].par),
                      $sformatf("vec%0d", i));

        // Back-to-back words with tx_valid held high.
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hFF;
        expect_frame(mk(10'b0000000001, 1'b0), 8'hFF, "b2b f1");
        @(negedge clk);
        tx_valid = 1'b0;
        expect_frame(mk(10'b0111111111, 1'b0), 8'hFF, "b2b f2");

        // Reset during DATA bit 3 of an all-zero word.
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre-abort line", tx_line, 1'b0);
        chk("pre-abort busy", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort line", tx_line, 1'b1);
        chk("abort busy", busy, 1'b0);
        chk("abort ready", tx_ready, 1'b1);
        // Reset must win over a handshake on the same edge.
        tx_valid = 1'b1;
        @(negedge clk);
        chk("rst prio busy", busy, 1'b0);
        chk("rst prio line", tx_line, 1'b1);
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("no resend busy", busy, 1'b0);
            chk("no resend line", tx_line, 1'b1);
        end
        run_frame(8'h01, 8'hFE, mk(10'b0100000001, 1'b1), "post-reset");

        // One clock per bit.
        tx_data1  = 8'h81;
        tx_valid1 = 1'b1;
        @(negedge clk);
        tx_valid1 = 1'b0;
        begin
            logic [0:10] s1;
            s1 = mk(10'b0100000011, 1'b0);
            for (int b = 0; b < NB; b++) begin
                chk($sformatf("div1 line b%0d", b), tx_line1, s1[b]);
                chk($sformatf("div1 busy b%0d", b), busy1, 1'b1);
                @(negedge clk);
            end
        end
        chk("div1 ready after", tx_ready1, 1'b1);
        chk("div1 busy after", busy1, 1'b0);
        chk("div1 idle line", tx_line1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
